// File: rtl/iob_pcie_rx_pkg.sv
// Shared types and constants for the RIFFA RX unpacker: FSM encoding and
// the layout of a buffered beat (data plus two tag bits above it).
package iob_pcie_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    RECV  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int TAG_W = 2;
  // Tag positions counted from the first bit above the beat data.
  localparam int HALF  = 0;
  localparam int LAST  = 1;

  function automatic int entry_width(input int pci_w);
    return pci_w + TAG_W;
  endfunction

endpackage

// File: rtl/iob_pcie_rx_fifo.sv
// Synchronous beat FIFO. 'mark' sets MARK_BIT of the most recently written
// entry so a truncated transaction can be closed after its final beat was queued.
module iob_pcie_rx_fifo #(
  parameter int WIDTH    = 66,
  parameter int ADDR_W   = 3,
  parameter int MARK_BIT = 65
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              mark,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] tail_ptr;
  logic              do_push;
  logic              do_pop;
  logic              do_mark;

  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign tail_ptr = wr_ptr - ADDR_W'(1);
  // A mark is lost if the tail entry is leaving in the same cycle.
  assign do_mark  = mark & ~empty & ~do_push & ~(do_pop & (count == (ADDR_W+1)'(1)));
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
    if (do_mark) mem[tail_ptr][MARK_BIT] <= 1'b1;
  end

endmodule

// File: rtl/iob_pcie_rx_unpack.sv
// Terminates one RIFFA RX channel: buffers 64-bit beats and unpacks them into
// 32-bit words, low half first, on a valid/ready stream.
module iob_pcie_rx_unpack
  import iob_pcie_rx_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 2*DATA_W,
  parameter int FIFO_ADDR_W      = 3
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        chnl_rx,
  output logic                        chnl_rx_ack,
  input  logic                        chnl_rx_last,
  input  logic [DATA_W-1:0]           chnl_rx_len,
  input  logic [DATA_W-2:0]           chnl_rx_off,
  input  logic [C_PCI_DATA_WIDTH-1:0] chnl_rx_data,
  input  logic                        chnl_rx_data_valid,
  output logic                        chnl_rx_data_ren,
  output logic                        m_valid,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        short_err,
  output logic [1:0]                  dbg_state
);

  localparam int ENTRY_W  = entry_width(C_PCI_DATA_WIDTH);
  localparam int HALF_BIT = C_PCI_DATA_WIDTH + HALF;
  localparam int LAST_BIT = C_PCI_DATA_WIDTH + LAST;
  localparam int DEPTH    = 1 << FIFO_ADDR_W;

  state_t               state;
  state_t               state_nxt;
  logic [DATA_W-1:0]    len_r;
  logic [DATA_W-1:0]    rcv_cnt;
  logic [DATA_W-1:0]    rem;
  logic [DATA_W-1:0]    take;
  logic [DATA_W-1:0]    cnt_after;
  logic                 ren;
  logic                 accept;
  logic                 mark;
  logic                 set_short;
  logic                 short_err_r;
  logic                 sel;
  logic                 fire;
  logic                 pop;
  logic [ENTRY_W-1:0]   din;
  logic [ENTRY_W-1:0]   head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [FIFO_ADDR_W:0] fifo_count;
  logic                 unused_ok;

  assign unused_ok = ^{chnl_rx_last, chnl_rx_off, fifo_full};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Beats and words both follow valid/ready: a transfer happens on the rising
  // edge where valid and ready (ren for beats) are both high; ren depends only
  // on registered state so it never reacts combinationally to a same-cycle pop.
  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    accept    = 1'b0;
    mark      = 1'b0;
    set_short = 1'b0;
    rem       = len_r - rcv_cnt;
    take      = (rem > DATA_W'(2)) ? DATA_W'(2) : rem;
    cnt_after = rcv_cnt + take;
    case (state)
      IDLE:  if (chnl_rx) state_nxt = ACK;
      ACK:   state_nxt = (len_r != '0) ? RECV : IDLE;
      RECV: begin
        ren    = (fifo_count < (FIFO_ADDR_W+1)'(DEPTH));
        accept = ren & chnl_rx_data_valid;
        if (accept && (cnt_after == len_r)) state_nxt = DRAIN;
        if (!chnl_rx) begin
          state_nxt = DRAIN;
          set_short = accept ? (cnt_after != len_r) : 1'b1;
          mark      = ~accept;
        end
      end
      DRAIN: if (fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign din = {((rem <= DATA_W'(2)) | ~chnl_rx), (rem == DATA_W'(1)), chnl_rx_data};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      len_r       <= '0;
      rcv_cnt     <= '0;
      short_err_r <= 1'b0;
      sel         <= 1'b0;
    end else begin
      if (state == IDLE && chnl_rx) begin
        len_r   <= chnl_rx_len;
        rcv_cnt <= '0;
      end
      if (accept) rcv_cnt <= cnt_after;
      if (state == ACK)   short_err_r <= 1'b0;
      else if (set_short) short_err_r <= 1'b1;
      if (fire) sel <= ~sel & ~head[HALF_BIT];
    end
  end

  iob_pcie_rx_fifo #(
    .WIDTH    (ENTRY_W),
    .ADDR_W   (FIFO_ADDR_W),
    .MARK_BIT (LAST_BIT)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (accept),
    .pop    (pop),
    .mark   (mark),
    .din    (din),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign m_valid          = ~fifo_empty;
  assign m_data           = m_valid ? (sel ? head[DATA_W +: DATA_W] : head[DATA_W-1:0]) : '0;
  assign m_last           = m_valid & head[LAST_BIT] & (sel | head[HALF_BIT]);
  assign fire             = m_valid & m_ready;
  assign pop              = fire & (sel | head[HALF_BIT]);
  assign chnl_rx_ack      = (state == ACK);
  assign chnl_rx_data_ren = ren;
  assign busy             = (state != IDLE);
  assign short_err        = short_err_r;
  assign dbg_state        = state;

endmodule

// File: tb/tb_iob_pcie_rx_unpack.sv
// Bench for iob_pcie_rx_unpack: a word-level model of each transaction feeds
// an expected queue that a monitor compares against the output stream.
`timescale 1ns/1ps
module tb_iob_pcie_rx_unpack;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          chnl_rx = 1'b0;
  logic          chnl_rx_last = 1'b0;
  logic [W-1:0]  chnl_rx_len = '0;
  logic [W-2:0]  chnl_rx_off = '0;
  logic [63:0]   chnl_rx_data = '0;
  logic          chnl_rx_data_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic          chnl_rx_ack;
  logic          chnl_rx_data_ren;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          short_err;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;
  int ack_cnt = 0;
  int ack_base = 0;
  int words_seen = 0;
  int tb_len = 0;
  int tb_sent = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    int len;
    int drop_k;
    int rmode;
    int exp_words;
    bit exp_short;
  } row_t;
  row_t rows[8];

  iob_pcie_rx_unpack dut (
    .clk                (clk),
    .arst_n             (arst_n),
    .chnl_rx            (chnl_rx),
    .chnl_rx_ack        (chnl_rx_ack),
    .chnl_rx_last       (chnl_rx_last),
    .chnl_rx_len        (chnl_rx_len),
    .chnl_rx_off        (chnl_rx_off),
    .chnl_rx_data       (chnl_rx_data),
    .chnl_rx_data_valid (chnl_rx_data_valid),
    .chnl_rx_data_ren   (chnl_rx_data_ren),
    .m_valid            (m_valid),
    .m_data             (m_data),
    .m_last             (m_last),
    .m_ready            (m_ready),
    .busy               (busy),
    .short_err          (short_err),
    .dbg_state          (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // sink ready pattern: 0 = hold low, 1 = always ready, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard: every word handshake is checked against the model queue
  always @(negedge clk) begin
    logic [W:0] e;
    if (chnl_rx_ack) ack_cnt++;
    if (arst_n && m_valid && m_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got data 0x%0h last %0d, want no word", m_data, m_last);
      end else begin
        e = exp_q.pop_front();
        check("word", {m_last, m_data}, e);
      end
    end
  end

  // driver tasks
  task automatic start_txn(input int len, input int rmode);
    bit found;
    ready_mode = rmode;
    tb_len = len;
    tb_sent = 0;
    ack_base = ack_cnt;
    @(posedge clk);
    #1;
    chnl_rx = 1'b1;
    chnl_rx_len = len;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (chnl_rx_ack) begin
        found = 1;
        break;
      end
    end
    check("ack_seen", found, 1);
    check("busy_in_ack", busy, 1);
    if (len == 0) chnl_rx = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", chnl_rx_ack, 0);
    check("short_err_clear_after_ack", short_err, 0);
  endtask

  // Model: a beat carries min(2, remaining) words, low half first; the word
  // that completes len is the last one.
  task automatic send_beat(input logic [63:0] d);
    int take;
    bit ok;
    take = (tb_len - tb_sent >= 2) ? 2 : tb_len - tb_sent;
    exp_q.push_back({(tb_sent + 1 == tb_len), d[31:0]});
    if (take == 2) exp_q.push_back({(tb_sent + 2 == tb_len), d[63:32]});
    tb_sent += take;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    chnl_rx_data_valid = 1'b1;
    chnl_rx_data = d;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (chnl_rx_data_ren) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_accept: got ren stuck low, want beat accepted");
    end
    @(posedge clk);
    #1;
    chnl_rx_data_valid = 1'b0;
    chnl_rx_data = {$urandom, $urandom};
  endtask

  // A dropped transaction closes on the last word already queued.
  task automatic end_txn(input bit drop, input bit exp_short);
    logic [W:0] e;
    bit done;
    chnl_rx = 1'b0;
    if (drop && exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e[W] = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    if (ready_mode == 0) ready_mode = 1;
    done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("txn_complete", done, 1);
    check("short_err", short_err, exp_short);
    check("ack_count", ack_cnt - ack_base, 1);
  endtask

  initial begin
    int nb;
    int base_words;
    rows = '{
      '{1,  0, 2, 1,  1'b0},
      '{2,  0, 2, 2,  1'b0},
      '{5,  0, 1, 5,  1'b0},
      '{7,  0, 2, 7,  1'b0},
      '{17, 0, 2, 17, 1'b0},
      '{33, 0, 2, 33, 1'b0},
      '{9,  2, 0, 4,  1'b1},
      '{16, 3, 0, 6,  1'b1}
    };

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {chnl_rx_ack, chnl_rx_data_ren, m_valid, m_last, busy, short_err, m_data}, 0);
    check("reset_state", dbg_state, 0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // len=4: words 1..4, last only on 4
    start_txn(4, 1);
    send_beat(64'h00000002_00000001);
    send_beat(64'h00000004_00000003);
    end_txn(0, 0);

    // len=3: high half of the second beat is never output
    start_txn(3, 1);
    send_beat(64'h0000000B_0000000A);
    send_beat(64'h0000FFFF_0000000C);
    end_txn(0, 0);

    // len=0: ACK only, idle two cycles after request
    start_txn(0, 1);
    check("len0_busy_low", busy, 0);
    check("len0_no_valid", m_valid, 0);
    end_txn(0, 0);

    // len=20 with sink stalled: FIFO fills at 8 beats
    start_txn(20, 0);
    for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ren_low_when_full", chnl_rx_data_ren, 0);
    end
    check("full_m_valid", m_valid, 1);
    ready_mode = 1;
    for (int b = 8; b < 10; b++) send_beat({$urandom, $urandom});
    end_txn(0, 0);

    // len=8 dropped after 2 beats; next ACK clears short_err
    start_txn(8, 0);
    send_beat({$urandom, $urandom});
    send_beat({$urandom, $urandom});
    end_txn(1, 1);

    // table rows
    foreach (rows[i]) begin
      base_words = words_seen;
      start_txn(rows[i].len, rows[i].rmode);
      nb = (rows[i].drop_k != 0) ? rows[i].drop_k : (rows[i].len + 1) / 2;
      for (int b = 0; b < nb; b++) send_beat({$urandom, $urandom});
      end_txn(rows[i].drop_k != 0, rows[i].exp_short);
      check("row_words", words_seen - base_words, rows[i].exp_words);
    end

    // random lengths and random sink stalls
    for (int t = 0; t < 6; t++) begin
      nb = $urandom_range(1, 40);
      start_txn(nb, 2);
      for (int b = 0; b < (nb + 1) / 2; b++) send_beat({$urandom, $urandom});
      end_txn(0, 0);
    end

    // reset in the middle of RECV with 5 beats queued
    start_txn(12, 0);
    for (int b = 0; b < 5; b++) send_beat({$urandom, $urandom});
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    chnl_rx = 1'b0;
    #1;
    check("rst_mid_outputs", {chnl_rx_ack, chnl_rx_data_ren, m_valid, m_last, busy, short_err, m_data}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    check("rst_mid_state", dbg_state, 0);
    start_txn(2, 1);
    send_beat({$urandom, $urandom});
    end_txn(0, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
